// File: rtl/axi4_lite_adder_bank.sv
// AXI4-Lite register bank: NUM_OPS operand registers, an on-demand SUM register
// computed by a multi-cycle accumulator, and a STATUS register holding its carry.
module axi4_lite_adder_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OPS    = 4,
  parameter int ADDR_BITS  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               S_AXI_AWADDR,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [31:0]               S_AXI_ARADDR,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  input  logic [2:0]                S_AXI_ARPROT,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_BITS - 2;
  localparam int CNT_W  = $clog2(NUM_OPS);
  localparam logic [IDX_W-1:0] SUM_IDX  = IDX_W'(NUM_OPS);
  localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(NUM_OPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_OPS - 1);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic       {W_IDLE, W_RESP}         w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_SUM, R_DATA}  r_state_t;

  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH:0] add_carry(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

  w_state_t              w_state_q, w_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] ops_q [NUM_OPS];
  logic [DATA_WIDTH-1:0] ops_d [NUM_OPS];

  r_state_t              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      r_cnt_q, r_cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  carry_run_q, carry_run_d;
  logic                  carry_q, carry_d;

  logic                  aw_hs, w_hs, ar_hs, sum_start, sum_busy;
  logic [IDX_W-1:0]      ar_idx, cur_aw_idx;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [STRB_W-1:0]     cur_wstrb;
  logic [DATA_WIDTH:0]   sum_w;

  assign aw_hs      = S_AXI_AWVALID & awready_q;
  assign w_hs       = S_AXI_WVALID & wready_q;
  assign ar_hs      = S_AXI_ARVALID & arready_q;
  assign ar_idx     = S_AXI_ARADDR[ADDR_BITS-1:2];
  assign sum_start  = (r_state_q == R_IDLE) & ar_hs & (ar_idx == SUM_IDX);
  // A SUM accumulation starting or running freezes operand writes.
  assign sum_busy   = (r_state_q == R_SUM) | sum_start;
  assign cur_aw_idx = aw_hs ? S_AXI_AWADDR[ADDR_BITS-1:2] : aw_idx_q;
  assign cur_wdata  = w_hs ? S_AXI_WDATA : w_data_q;
  assign cur_wstrb  = w_hs ? S_AXI_WSTRB : w_strb_q;

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ops_d     = ops_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = !(aw_held_q | aw_hs);
        wready_d  = !(w_held_q | w_hs);
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[ADDR_BITS-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = S_AXI_WDATA;
          w_strb_d = S_AXI_WSTRB;
        end
        if ((aw_held_q | aw_hs) && (w_held_q | w_hs) && !sum_busy) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (cur_aw_idx < SUM_IDX) begin
            ops_d[cur_aw_idx[CNT_W-1:0]] =
              apply_strb(ops_q[cur_aw_idx[CNT_W-1:0]], cur_wdata, cur_wstrb);
            bresp_d = RESP_OKAY;
          end else if (cur_aw_idx == SUM_IDX || cur_aw_idx == STAT_IDX) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d = RESP_DECERR;
          end
        end
      end
      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    r_cnt_d     = r_cnt_q;
    acc_d       = acc_q;
    carry_run_d = carry_run_q;
    carry_d     = carry_q;
    sum_w       = add_carry(acc_q, ops_q[r_cnt_q]);
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          if (ar_idx == SUM_IDX) begin
            r_state_d   = R_SUM;
            acc_d       = '0;
            carry_run_d = 1'b0;
            r_cnt_d     = '0;
          end else begin
            r_state_d = R_DATA;
            rvalid_d  = 1'b1;
            rdata_d   = '0;
            rresp_d   = RESP_OKAY;
            if (ar_idx < SUM_IDX) rdata_d = ops_q[ar_idx[CNT_W-1:0]];
            else if (ar_idx == STAT_IDX) rdata_d[0] = carry_q;
            else rresp_d = RESP_DECERR;
          end
        end
      end
      // One operand per cycle; carry is sticky across the partial sums.
      R_SUM: begin
        arready_d   = 1'b0;
        acc_d       = sum_w[DATA_WIDTH-1:0];
        carry_run_d = carry_run_q | sum_w[DATA_WIDTH];
        r_cnt_d     = r_cnt_q + CNT_W'(1);
        if (r_cnt_q == CNT_LAST) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = sum_w[DATA_WIDTH-1:0];
          rresp_d   = RESP_OKAY;
          carry_d   = carry_run_q | sum_w[DATA_WIDTH];
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
      r_state_q   <= R_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      r_cnt_q     <= '0;
      acc_q       <= '0;
      carry_run_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      ops_q       <= ops_d;
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      r_cnt_q     <= r_cnt_d;
      acc_q       <= acc_d;
      carry_run_q <= carry_run_d;
      carry_q     <= carry_d;
    end
  end

  // Address/data capture registers need no reset: they are qualified by the held flags.
  always_ff @(posedge clk) begin
    aw_idx_q <= aw_idx_d;
    w_data_q <= w_data_d;
    w_strb_q <= w_strb_d;
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWADDR[31:ADDR_BITS], S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[31:ADDR_BITS], S_AXI_ARADDR[1:0],
                       S_AXI_AWPROT, S_AXI_ARPROT};

endmodule

// File: tb/tb_axi4_lite_adder_bank.sv
// Directed bench for axi4_lite_adder_bank (DATA_WIDTH=32, NUM_OPS=4, ADDR_BITS=7).
module tb_axi4_lite_adder_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [3:0]  WSTRB = '0;
  logic [2:0]  AWPROT = '0, ARPROT = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi4_lite_adder_bank #(.DATA_WIDTH(32), .NUM_OPS(4), .ADDR_BITS(7)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY), .S_AXI_AWPROT(AWPROT),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY), .S_AXI_ARPROT(ARPROT),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
    bit aw_ok, w_ok;
    int t;
    aw_ok = 0; w_ok = 0; t = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    while (!(aw_ok && w_ok) && t < 50) begin
      if (AWREADY) aw_ok = 1;
      if (WREADY)  w_ok = 1;
      @(negedge clk); t++;
      if (aw_ok) AWVALID = 1'b0;
      if (w_ok)  WVALID = 1'b0;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("wr_handshake", {62'd0, aw_ok, w_ok}, 64'd3);
    lat = 1;
    while (!BVALID && lat < 60) begin @(negedge clk); lat++; end
    resp = BRESP;
    @(negedge clk);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit ok;
    int t;
    ok = 0; t = 0;
    ARADDR = addr; ARVALID = 1'b1;
    while (!ok && t < 50) begin
      if (ARREADY) ok = 1;
      @(negedge clk); t++;
    end
    ARVALID = 1'b0;
    check("rd_handshake", {63'd0, ok}, 64'd1);
    lat = 1;
    while (!RVALID && lat < 60) begin @(negedge clk); lat++; end
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;
    int          lat, rl, bl;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    check("rst_valid", {62'd0, BVALID, RVALID}, 64'd0);
    check("rst_data", {28'd0, BRESP, RRESP, RDATA}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);

    // Simple sum: 5 + 7 = 0xC
    axi_write(32'h00, 32'h5, 4'hF, br, lat);
    check("w_op0_resp", br, 0);
    check("w_op0_lat", lat, 1);
    axi_write(32'h04, 32'h7, 4'hF, br, lat);
    check("w_op1_resp", br, 0);
    axi_read(32'h10, rd, rr, lat);
    check("sum1_data", rd, 32'h0000000C);
    check("sum1_resp", rr, 0);
    check("sum1_lat", lat, 5);
    axi_read(32'h14, rd, rr, lat);
    check("status1", rd, 0);
    check("status_lat", lat, 1);

    // Overflow: FFFFFFFF + 2 -> 1 with carry
    axi_write(32'h00, 32'hFFFFFFFF, 4'hF, br, lat);
    axi_write(32'h04, 32'h00000002, 4'hF, br, lat);
    axi_read(32'h10, rd, rr, lat);
    check("sum2_data", rd, 32'h00000001);
    check("sum2_resp", rr, 0);
    axi_read(32'h14, rd, rr, lat);
    check("status2", rd, 32'h00000001);

    // Byte strobes
    axi_write(32'h08, 32'h11223344, 4'hF, br, lat);
    axi_write(32'h08, 32'hAABBCCDD, 4'h5, br, lat);
    check("strb_resp", br, 0);
    axi_read(32'h08, rd, rr, lat);
    check("strb_data", rd, 32'h11BB33DD);
    axi_write(32'h08, 32'h99999999, 4'h0, br, lat);
    check("strb0_resp", br, 0);
    axi_read(32'h08, rd, rr, lat);
    check("strb0_data", rd, 32'h11BB33DD);

    // Error responses
    axi_write(32'h10, 32'h12345678, 4'hF, br, lat);
    check("w_sum_slverr", br, 2);
    axi_write(32'h14, 32'h12345678, 4'hF, br, lat);
    check("w_status_slverr", br, 2);
    axi_write(32'h40, 32'h12345678, 4'hF, br, lat);
    check("w_unmapped_decerr", br, 3);
    axi_read(32'h40, rd, rr, lat);
    check("r_unmapped_resp", rr, 3);
    check("r_unmapped_data", rd, 0);
    axi_read(32'h14, rd, rr, lat);
    check("status_after_err", rd, 32'h00000001);
    axi_read(32'h80, rd, rr, lat);
    check("alias_op0", rd, 32'hFFFFFFFF);
    axi_read(32'h07, rd, rr, lat);
    check("op1_low_bits_ignored", rd, 32'h00000002);

    // AW three cycles ahead of W, BREADY held low
    AWADDR = 32'h0C; WDATA = 32'hCAFE0003; WSTRB = 4'hF; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    check("split_awready_low", {62'd0, AWREADY, WREADY}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("split_no_bvalid", BVALID, 0);
    WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("split_hold", {61'd0, BVALID, AWREADY, WREADY}, 64'd4);
      if (k < 3) @(negedge clk);
    end
    check("split_bresp", BRESP, 0);
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check("split_bvalid_clear", BVALID, 0);
    axi_read(32'h0C, rd, rr, lat);
    check("split_data", rd, 32'hCAFE0003);

    // Interlock: SUM read and OP0 write issued together
    axi_write(32'h00, 32'h10, 4'hF, br, lat);
    axi_write(32'h04, 32'h20, 4'hF, br, lat);
    axi_write(32'h08, 32'h00, 4'hF, br, lat);
    axi_write(32'h0C, 32'h01, 4'hF, br, lat);
    ARADDR = 32'h10; ARVALID = 1'b1;
    AWADDR = 32'h00; WDATA = 32'h100; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    BREADY = 1'b1;
    rl = 0; bl = 0; rd = '0; rr = '0; br = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; end
      if (RVALID && rl == 0) begin rl = k; rd = RDATA; rr = RRESP; RREADY = 1'b1; end
      else RREADY = 1'b0;
      if (BVALID && bl == 0) begin bl = k; br = BRESP; end
    end
    BREADY = 1'b0; RREADY = 1'b0;
    check("lock_sum_old", rd, 32'h31);
    check("lock_rresp", rr, 0);
    check("lock_rlat", rl, 5);
    check("lock_blat", bl, 6);
    check("lock_bresp", br, 0);
    axi_read(32'h10, rd, rr, lat);
    check("lock_sum_new", rd, 32'h121);
    axi_read(32'h14, rd, rr, lat);
    check("lock_status", rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
